// File: rtl/sm83_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : sm83_alu_seq
// Description : Sequencer that runs an 8-bit operation on a 4-bit nibble ALU
//               in two passes (low nibble, then high nibble) and collects the
//               result and Z/N/H/C flags. Optional feature macro:
//               SM83_ALU_SEQ_CP_EN - op 111 is CP (flags only, result kept);
//               when undefined op 111 behaves exactly as SUB.
// Revision    : 1.0 - initial release
// ============================================================================
module sm83_alu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       cin,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c,
  output logic [7:0] alu_din,
  output logic       alu_load_a,
  output logic       alu_load_b,
  output logic       alu_shift_oe,
  output logic       alu_result_oe,
  output logic       alu_op_low,
  output logic       alu_op_b_high,
  output logic       alu_negate,
  output logic       alu_carry_in,
  output logic       alu_no_carry_out,
  output logic       alu_force_carry,
  output logic       alu_ignore_carry,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic [7:0] alu_dout
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_ADC = 3'b001;
  localparam logic [2:0] c_OP_SUB = 3'b010;
  localparam logic [2:0] c_OP_SBC = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_XOR = 3'b101;
  localparam logic [2:0] c_OP_OR  = 3'b110;
  localparam logic [2:0] c_OP_CP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_LOW  = 3'd3,
    S_HIGH = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic       r_hc;
  logic       r_fc;
  logic       r_done;
  logic [7:0] r_result;
  logic       r_flag_z;
  logic       r_flag_n;
  logic       r_flag_h;
  logic       r_flag_c;

  logic       w_sub;
  logic       w_arith;
  logic       w_low_cin;
  logic       w_keep_result;

  // Subtract-class ops run the adder with B negated; op 111 always subtracts.
  assign w_sub   = (r_op == c_OP_SUB) || (r_op == c_OP_SBC) || (r_op == c_OP_CP);
  assign w_arith = !r_op[2] || (r_op == c_OP_CP);

`ifdef SM83_ALU_SEQ_CP_EN
  assign w_keep_result = (r_op == c_OP_CP);
`else
  assign w_keep_result = 1'b0;
`endif

  // Carry injected into the low nibble pass for each op.
  always_comb begin
    w_low_cin = 1'b0;
    case (r_op)
      c_OP_ADD: w_low_cin = 1'b0;
      c_OP_ADC: w_low_cin = r_cin;
      c_OP_SUB: w_low_cin = 1'b1;
      c_OP_SBC: w_low_cin = !r_cin;
      c_OP_AND: w_low_cin = 1'b1;
      c_OP_XOR: w_low_cin = 1'b0;
      c_OP_OR:  w_low_cin = 1'b0;
      c_OP_CP:  w_low_cin = 1'b1;
      default:  w_low_cin = 1'b0;
    endcase
  end

  // ALU control decode from current state and latched op.
  always_comb begin
    alu_din          = 8'h00;
    alu_load_a       = 1'b0;
    alu_load_b       = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_result_oe    = 1'b0;
    alu_op_low       = 1'b0;
    alu_op_b_high    = 1'b0;
    alu_negate       = 1'b0;
    alu_carry_in     = 1'b0;
    alu_no_carry_out = 1'b0;
    alu_force_carry  = 1'b0;
    alu_ignore_carry = 1'b0;
    case (r_state)
      S_LD_A: begin
        alu_shift_oe = 1'b1;
        alu_load_a   = 1'b1;
        alu_din      = r_a;
      end
      S_LD_B: begin
        alu_shift_oe = 1'b1;
        alu_load_b   = 1'b1;
        alu_din      = r_b;
      end
      S_LOW, S_HIGH: begin
        alu_op_low       = (r_state == S_LOW);
        alu_op_b_high    = (r_state == S_HIGH);
        alu_negate       = w_sub;
        alu_force_carry  = (r_op == c_OP_AND);
        alu_no_carry_out = (r_op == c_OP_XOR) || (r_op == c_OP_OR);
        alu_ignore_carry = (r_op == c_OP_OR);
        // High pass chains the nibble carry only for arithmetic ops.
        alu_carry_in     = ((r_state == S_HIGH) && w_arith) ? r_hc : w_low_cin;
      end
      S_WB: begin
        alu_result_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
  assign flag_h = r_flag_h;
  assign flag_c = r_flag_c;

  // Sequencer FSM with operand latching, carry capture and writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_cin    <= 1'b0;
      r_hc     <= 1'b0;
      r_fc     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 8'h00;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_h <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_op    <= op;
            r_a     <= a_in;
            r_b     <= b_in;
            r_cin   <= cin;
            r_state <= S_LD_A;
          end
        end
        S_LD_A: r_state <= S_LD_B;
        S_LD_B: r_state <= S_LOW;
        S_LOW: begin
          r_hc    <= alu_carry;
          r_state <= S_HIGH;
        end
        S_HIGH: begin
          r_fc    <= alu_carry;
          r_state <= S_WB;
        end
        S_WB: begin
          if (!w_keep_result) begin
            r_result <= alu_dout;
          end
          r_flag_z <= alu_zero;
          r_flag_n <= w_sub;
          // Carry/borrow polarity flips for subtract-class ops.
          r_flag_h <= w_arith ? (r_hc ^ w_sub) : (r_op == c_OP_AND);
          r_flag_c <= w_arith ? (r_fc ^ w_sub) : 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm83_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm83_alu_seq
// Description : Scoreboard bench for sm83_alu_seq with a behavioural nibble
//               ALU attached and an 8-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm83_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       cin = 1'b0;
  logic       ready, done;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_h, flag_c;
  logic [7:0] alu_din;
  logic       alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe;
  logic       alu_op_low, alu_op_b_high, alu_negate, alu_carry_in;
  logic       alu_no_carry_out, alu_force_carry, alu_ignore_carry;
  logic       alu_carry, alu_zero;
  logic [7:0] alu_dout;

  sm83_alu_seq dut (
    .clk              (clk),
    .reset            (rst),
    .req              (req),
    .op               (op),
    .a_in             (a_in),
    .b_in             (b_in),
    .cin              (cin),
    .ready            (ready),
    .done             (done),
    .result           (result),
    .flag_z           (flag_z),
    .flag_n           (flag_n),
    .flag_h           (flag_h),
    .flag_c           (flag_c),
    .alu_din          (alu_din),
    .alu_load_a       (alu_load_a),
    .alu_load_b       (alu_load_b),
    .alu_shift_oe     (alu_shift_oe),
    .alu_result_oe    (alu_result_oe),
    .alu_op_low       (alu_op_low),
    .alu_op_b_high    (alu_op_b_high),
    .alu_negate       (alu_negate),
    .alu_carry_in     (alu_carry_in),
    .alu_no_carry_out (alu_no_carry_out),
    .alu_force_carry  (alu_force_carry),
    .alu_ignore_carry (alu_ignore_carry),
    .alu_carry        (alu_carry),
    .alu_zero         (alu_zero),
    .alu_dout         (alu_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural nibble ALU driven by the sequencer's control lines.
  logic [7:0] alu_a = 8'h00, alu_b = 8'h00, alu_r = 8'h00;
  logic [3:0] na, nb, nbx, nres;
  logic [4:0] nsum;
  logic       last_low_cin = 1'b0;

  always_comb begin
    na   = alu_op_low ? alu_a[3:0] : alu_a[7:4];
    nb   = alu_op_b_high ? alu_b[7:4] : alu_b[3:0];
    nbx  = alu_negate ? ~nb : nb;
    nsum = {1'b0, na} + {1'b0, nbx} + {4'b0, alu_carry_in};
    nres = nsum[3:0];
    alu_carry = 1'b0;
    if (alu_force_carry) begin
      nres = na & nb;
    end else if (alu_no_carry_out && alu_ignore_carry) begin
      nres = na | nb;
    end else if (alu_no_carry_out) begin
      nres = na ^ nb;
    end else begin
      alu_carry = (alu_op_low || alu_op_b_high) ? nsum[4] : 1'b0;
    end
  end

  always @(posedge clk) begin
    if (alu_load_a) alu_a <= alu_din;
    if (alu_load_b) alu_b <= alu_din;
    if (alu_op_low) begin
      alu_r[3:0]   <= nres;
      last_low_cin <= alu_carry_in;
    end
    if (alu_op_b_high) alu_r[7:4] <= nres;
  end

  assign alu_dout = alu_result_oe ? alu_r : 8'h00;
  assign alu_zero = (alu_r == 8'h00);

  typedef struct {
    logic [7:0] res;
    logic       z, n, h, c, lcin;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] prev_result = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 8-bit arithmetic with explicit nibble/byte carry rules.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic [7:0] prev);
    exp_t e;
    int   ia = int'(a), ib = int'(b), c1 = int'(ci), r = 0;
    logic [31:0] rv;
    e.n = 1'b0; e.h = 1'b0; e.c = 1'b0; e.lcin = 1'b0; e.cyc = 0;
    case (o)
      3'd0, 3'd1: begin
        if (o == 3'd0) c1 = 0;
        r      = ia + ib + c1;
        e.h    = ((ia % 16) + (ib % 16) + c1) > 15;
        e.c    = r > 255;
        e.lcin = (o == 3'd1) ? ci : 1'b0;
      end
      3'd2, 3'd3, 3'd7: begin
        if (o != 3'd3) c1 = 0;
        r      = ia - ib - c1;
        e.n    = 1'b1;
        e.h    = (ia % 16) < ((ib % 16) + c1);
        e.c    = ia < (ib + c1);
        e.lcin = (o == 3'd3) ? !ci : 1'b1;
      end
      3'd4: begin r = int'(a & b); e.h = 1'b1; e.lcin = 1'b1; end
      3'd5: r = int'(a ^ b);
      default: r = int'(a | b);
    endcase
    rv    = r;
    e.res = rv[7:0];
    e.z   = (e.res == 8'h00);
`ifdef SM83_ALU_SEQ_CP_EN
    if (o == 3'd7) e.res = prev;
`else
    if (prev == 8'h00) e.res = e.res;
`endif
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("flag_z", flag_z, e.z);
          chk("flag_n", flag_n, e.n);
          chk("flag_h", flag_h, e.h);
          chk("flag_c", flag_c, e.c);
          chk("low_carry_in", last_low_cin, e.lcin);
          chk("latency_edges", cyc - e.cyc + 1, 6);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input bit noise);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    op = o; a_in = a; b_in = b; cin = ci; req = 1'b1;
    e = model(o, a, b, ci, prev_result);
    @(posedge clk);
    #1;
    e.cyc = cyc;
    q.push_back(e);
    prev_result = e.res;
    @(negedge clk);
    req = 1'b0;
    if (noise) begin
      // Requests while busy must be ignored and must not disturb latched operands.
      for (int k = 0; k < 3; k++) begin
        req  = 1'($urandom_range(0, 1));
        op   = 3'($urandom);
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        cin  = 1'($urandom);
        @(negedge clk);
      end
      req = 1'b0;
    end
  endtask

  initial begin
    int n;
    int dcount;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_result", result, 8'h00);
    chk("reset_flags", {flag_z, flag_n, flag_h, flag_c}, 4'h0);

    issue(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0);   // ADD -> 00, Z H C
    issue(3'd2, 8'h10, 8'h01, 1'b0, 1'b0);   // SUB -> 0F, N H
    issue(3'd3, 8'h00, 8'h00, 1'b1, 1'b0);   // SBC -> FF, N H C
    issue(3'd4, 8'hF0, 8'h3C, 1'b0, 1'b1);   // AND -> 30, H
    issue(3'd5, 8'h3C, 8'h3C, 1'b0, 1'b0);   // XOR -> 00, Z
    issue(3'd0, 8'h50, 8'h05, 1'b0, 1'b0);   // result 55
    issue(3'd7, 8'h42, 8'h42, 1'b0, 1'b0);   // CP equal operands
    issue(3'd1, 8'h0F, 8'h00, 1'b1, 1'b0);   // ADC half-carry from cin
    issue(3'd6, 8'hA0, 8'h05, 1'b1, 1'b0);   // OR

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset during the high-nibble pass aborts the operation.
    issue(3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    n = 0;
    while (!alu_op_b_high && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reached_high", alu_op_b_high, 1);
    rst = 1'b1;
    q.delete();
    prev_result = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready, 1);
    chk("abort_result", result, 8'h00);
    chk("abort_flags", {flag_z, flag_n, flag_h, flag_c}, 4'h0);
    chk("abort_controls", {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low,
                           alu_op_b_high, alu_negate, alu_carry_in, alu_no_carry_out,
                           alu_force_carry, alu_ignore_carry}, 11'h0);
    chk("abort_din", alu_din, 8'h00);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", dcount, 0);

    issue(3'd2, 8'h00, 8'h01, 1'b0, 1'b1);   // borrow wrap after recovery

    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
